nonce_result_scanner: RTL and testbench

//  Reads back the NUM_NONCES hash words (H0 of each nonce, nonce order) written by the bitcoin hasher
//  at result_addr. Selects the numerically smallest hash, compares it against a 32-bit difficulty target
//  and reports the winning nonce. Shares the same single-port word memory, with the same start/done handshake.

---
 rtl/btc_pkg.sv | 28 ++
 rtl/min_tracker.sv | 63 ++++++
 rtl/nonce_result_scanner.sv | 183 ++++++++++++++++++
 tb/tb_nonce_result_scanner.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/btc_pkg.sv
// Shared definitions for the bitcoin hasher and the nonce result scanner.
// Holds the scanner state encoding, hash/nonce/count widths, the
// all-ones hash seed, and the packed result bundle the min tracker drives.
package btc_pkg;

  localparam int HASH_W  = 32;
  localparam int NONCE_W = 8;
  localparam int CNT_W   = 9;   // counts 0..256 matches

  // Seed for the running minimum; every real hash compares <= to it.
  localparam logic [HASH_W-1:0] HASH_INIT = 32'hFFFF_FFFF;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    SCAN = 3'd1,
    WB0  = 3'd2,
    WB1  = 3'd3,
    DONE = 3'd4
  } state_t;

  typedef struct packed {
    logic [NONCE_W-1:0] nonce;
    logic [HASH_W-1:0]  hash;
    logic               found;
    logic [CNT_W-1:0]   cnt;
  } result_t;

endpackage

// File: rtl/min_tracker.sv
// Running-minimum tracker for the nonce result scanner.
// Ports:
//   clk, reset_n  clock / async active-low reset
//   i_clr         reload seed state (start of a scan)
//   i_vld         i_word / i_idx hold a captured hash this cycle
//   i_last        this capture is the final nonce; latch found
//   i_word        captured hash word
//   i_idx         nonce index of i_word
//   i_target      difficulty target latched at start
//   o_res         best nonce, best hash, found flag, match count
module min_tracker
  import btc_pkg::*;
(
  input  logic               clk,
  input  logic               reset_n,
  input  logic               i_clr,
  input  logic               i_vld,
  input  logic               i_last,
  input  logic [HASH_W-1:0]  i_word,
  input  logic [NONCE_W-1:0] i_idx,
  input  logic [HASH_W-1:0]  i_target,
  output result_t            o_res
);

  logic [NONCE_W-1:0] r_nonce;
  logic [HASH_W-1:0]  r_hash;
  logic               r_found;
  logic [CNT_W-1:0]   r_cnt;

  logic               w_lt_best;
  logic               w_lt_tgt;
  logic [HASH_W-1:0]  w_new_best;

  // Strict compare: an equal later hash never displaces an earlier nonce.
  assign w_lt_best  = i_word < r_hash;
  assign w_lt_tgt   = i_word < i_target;
  assign w_new_best = w_lt_best ? i_word : r_hash;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_nonce <= '0;
      r_hash  <= HASH_INIT;
      r_found <= 1'b0;
      r_cnt   <= '0;
    end else if (i_clr) begin
      r_nonce <= '0;
      r_hash  <= HASH_INIT;
      r_found <= 1'b0;
      r_cnt   <= '0;
    end else if (i_vld) begin
      if (w_lt_best) begin
        r_hash  <= i_word;
        r_nonce <= i_idx;
      end
      if (w_lt_tgt) r_cnt <= r_cnt + 1'b1;
      // Use the minimum including this capture, not last cycle's.
      if (i_last) r_found <= w_new_best < i_target;
    end
  end

  assign o_res = '{nonce: r_nonce, hash: r_hash, found: r_found, cnt: r_cnt};

endmodule

// File: rtl/nonce_result_scanner.sv
// Nonce result scanner: reads NUM_NONCES hash words (H0 per nonce) from
// the shared single-port memory starting at result_addr, tracks the
// smallest one and counts hashes below the difficulty target.
// Optional feature macro BEST_WRITEBACK_EN: after the scan, writes
// {24'b0,best_nonce} to base+NUM_NONCES and best_hash to base+NUM_NONCES+1.
// Ports:
//   clk, reset_n              clock / async active-low reset
//   start, result_addr,target start handshake; base and target sampled with start
//   done                      results valid
//   mem_clk, mem_we, mem_addr, mem_write_data, mem_read_data
//                             memory port (read data is one cycle late)
//   best_nonce, best_hash, found, match_count   scan results
module nonce_result_scanner
  import btc_pkg::*;
#(
  parameter int NUM_NONCES = 16,
  parameter int ADDR_W     = 16
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               start,
  input  logic [ADDR_W-1:0]  result_addr,
  input  logic [HASH_W-1:0]  target,
  output logic               done,
  output logic               mem_clk,
  output logic               mem_we,
  output logic [ADDR_W-1:0]  mem_addr,
  output logic [HASH_W-1:0]  mem_write_data,
  input  logic [HASH_W-1:0]  mem_read_data,
  output logic [NONCE_W-1:0] best_nonce,
  output logic [HASH_W-1:0]  best_hash,
  output logic               found,
  output logic [CNT_W-1:0]   match_count
);

  localparam int STAGES = 1;
  localparam logic [CNT_W-1:0]   N_CNT    = CNT_W'(NUM_NONCES);
  localparam logic [NONCE_W-1:0] LAST_IDX = NONCE_W'(NUM_NONCES - 1);

  state_t              r_state, w_next;
  logic [ADDR_W-1:0]   r_base;
  logic [HASH_W-1:0]   r_target;
  logic [CNT_W-1:0]    r_rd_idx;
  logic [NONCE_W-1:0]  r_cap_idx;
  logic [STAGES:0]     vld_pipe;   // [0] addr issued, [1] its word is on mem_read_data
  logic                r_fin;      // last word captured on the previous edge
  logic                r_done;
  logic [ADDR_W-1:0]   r_mem_addr;

  logic                w_start;
  logic                w_issue;
  logic                w_cap;
  logic                w_last_cap;
  result_t             w_res;

  assign w_start    = ((r_state == IDLE) || (r_state == DONE)) && start;
  assign w_issue    = (r_state == SCAN) && (r_rd_idx < N_CNT);
  assign w_cap      = (r_state == SCAN) && vld_pipe[STAGES];
  assign w_last_cap = w_cap && (r_cap_idx == LAST_IDX);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE: if (start) w_next = SCAN;
`ifdef BEST_WRITEBACK_EN
      SCAN: if (r_fin) w_next = WB0;
`else
      SCAN: if (r_fin) w_next = DONE;
`endif
      WB0:  w_next = WB1;
      WB1:  w_next = DONE;
      DONE: if (start) w_next = SCAN;
      default: w_next = IDLE;
    endcase
  end

`ifdef BEST_WRITEBACK_EN
  localparam logic [ADDR_W-1:0] WB_OFF0 = ADDR_W'(NUM_NONCES);
  localparam logic [ADDR_W-1:0] WB_OFF1 = ADDR_W'(NUM_NONCES + 1);
  logic              r_mem_we;
  logic [HASH_W-1:0] r_wdata;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_base     <= '0;
      r_target   <= '0;
      r_rd_idx   <= '0;
      r_cap_idx  <= '0;
      vld_pipe   <= '0;
      r_fin      <= 1'b0;
      r_done     <= 1'b0;
      r_mem_addr <= '0;
`ifdef BEST_WRITEBACK_EN
      r_mem_we   <= 1'b0;
      r_wdata    <= '0;
`endif
    end else begin
      unique case (r_state)
        IDLE, DONE: if (start) begin
          r_base     <= result_addr;
          r_target   <= target;
          r_mem_addr <= result_addr;   // word 0 issued on the start edge
          r_rd_idx   <= CNT_W'(1);
          r_cap_idx  <= '0;
          vld_pipe   <= {{STAGES{1'b0}}, 1'b1};
          r_fin      <= 1'b0;
          r_done     <= 1'b0;
`ifdef BEST_WRITEBACK_EN
          r_mem_we   <= 1'b0;
`endif
        end
        SCAN: begin
          vld_pipe <= {vld_pipe[STAGES-1:0], w_issue};
          if (w_issue) begin
            // Wraps modulo 2**ADDR_W by truncation.
            r_mem_addr <= r_base + ADDR_W'(r_rd_idx);
            r_rd_idx   <= r_rd_idx + 1'b1;
          end
          if (w_cap) r_cap_idx <= r_cap_idx + 1'b1;
          r_fin <= w_last_cap;
          if (r_fin) begin
`ifdef BEST_WRITEBACK_EN
            r_mem_we   <= 1'b1;
            r_mem_addr <= r_base + WB_OFF0;
            r_wdata    <= {{(HASH_W-NONCE_W){1'b0}}, w_res.nonce};
`else
            r_done     <= 1'b1;
`endif
          end
        end
`ifdef BEST_WRITEBACK_EN
        WB0: begin
          r_mem_we   <= 1'b1;
          r_mem_addr <= r_base + WB_OFF1;
          r_wdata    <= w_res.hash;
        end
        WB1: begin
          r_mem_we <= 1'b0;
          r_done   <= 1'b1;
        end
`else
        WB0, WB1: ;
`endif
        default: ;
      endcase
    end
  end

  min_tracker u_min (
    .clk      (clk),
    .reset_n  (reset_n),
    .i_clr    (w_start),
    .i_vld    (w_cap),
    .i_last   (w_last_cap),
    .i_word   (mem_read_data),
    .i_idx    (r_cap_idx),
    .i_target (r_target),
    .o_res    (w_res)
  );

  assign mem_clk     = clk;
  assign mem_addr    = r_mem_addr;
  assign done        = r_done;
  assign best_nonce  = w_res.nonce;
  assign best_hash   = w_res.hash;
  assign found       = w_res.found;
  assign match_count = w_res.cnt;

`ifdef BEST_WRITEBACK_EN
  assign mem_we         = r_mem_we;
  assign mem_write_data = r_wdata;
`else
  assign mem_we         = 1'b0;
  assign mem_write_data = '0;
`endif

endmodule

// File: tb/tb_nonce_result_scanner.sv
// Directed bench for nonce_result_scanner with a behavioural one-cycle-
// latency memory and a backdoor write port used to load hash words.
module tb_nonce_result_scanner;

  localparam int N = 16;
`ifdef BEST_WRITEBACK_EN
  localparam int LAT   = N + 4;
  localparam int WE_EX = 2;
`else
  localparam int LAT   = N + 2;
  localparam int WE_EX = 0;
`endif

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic [15:0] result_addr = '0;
  logic [31:0] target = '0;
  logic        done, mem_clk, mem_we;
  logic [15:0] mem_addr;
  logic [31:0] mem_write_data;
  logic [31:0] mem_read_data = '0;
  logic [7:0]  best_nonce;
  logic [31:0] best_hash;
  logic        found;
  logic [8:0]  match_count;

  logic        bd_we = 1'b0;
  logic [15:0] bd_addr = '0;
  logic [31:0] bd_data = '0;
  logic [31:0] mem [0:65535];

  int checks = 0;
  int errors = 0;
  int cyc, wecnt;

  always #5 clk = ~clk;

  always @(posedge mem_clk) begin
    if (bd_we)       mem[bd_addr]  <= bd_data;
    else if (mem_we) mem[mem_addr] <= mem_write_data;
    mem_read_data <= mem[mem_addr];
  end

  nonce_result_scanner #(.NUM_NONCES(N), .ADDR_W(16)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .result_addr(result_addr),
    .target(target), .done(done), .mem_clk(mem_clk), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_write_data(mem_write_data),
    .mem_read_data(mem_read_data), .best_nonce(best_nonce),
    .best_hash(best_hash), .found(found), .match_count(match_count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [15:0] a, input logic [31:0] d);
    @(negedge clk);
    bd_we = 1'b1; bd_addr = a; bd_data = d;
    @(posedge clk); #1 bd_we = 1'b0;
  endtask

  task automatic chk_res(input string tag, input logic [7:0] n, input logic [31:0] h,
                         input logic f, input logic [8:0] m);
    chk({tag, "_nonce"}, 32'(best_nonce), 32'(n));
    chk({tag, "_hash"},  best_hash, h);
    chk({tag, "_found"}, 32'(found), 32'(f));
    chk({tag, "_cnt"},   32'(match_count), 32'(m));
  endtask

  // Pulses start; counts edges until done (bounded). poke>0 raises start
  // again for one cycle mid-scan.
  task automatic run_scan(input logic [15:0] base, input logic [31:0] tgt, input int poke,
                          output int c, output int w);
    @(negedge clk);
    result_addr = base; target = tgt; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    c = 0; w = 0;
    chk("done_low_after_start", 32'(done), 32'd0);
    while (c < 100) begin
      @(posedge clk); #1 c++;
      if (mem_we) w++;
      start = (c == poke);
      if (done) break;
    end
    start = 1'b0;
  endtask

  initial begin
    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_we", 32'(mem_we), 32'd0);
    chk("rst_addr", 32'(mem_addr), 32'd0);
    chk("rst_wdata", mem_write_data, 32'd0);
    chk_res("rst", 8'd0, 32'hFFFF_FFFF, 1'b0, 9'd0);
    @(negedge clk) reset_n = 1'b1;

    // 1: basic minimum below target
    for (int k = 0; k < N; k++)
      wr(16'(k), (k == 0) ? 32'h90 : (k == 1) ? 32'h50 : (k == 2) ? 32'h70 : 32'hFFFF_FFFF);
    run_scan(16'h0000, 32'h60, 0, cyc, wecnt);
    chk("t1_lat", 32'(cyc), 32'(LAT));
    chk("t1_we_cycles", 32'(wecnt), 32'(WE_EX));
    chk_res("t1", 8'd1, 32'h50, 1'b1, 9'd1);

    // 2: tie at words 3 and 9 keeps the lower nonce
    for (int k = 0; k < N; k++)
      wr(16'h0200 + 16'(k), (k == 3 || k == 9) ? 32'h1234 : 32'h10000 + 32'(k));
    run_scan(16'h0200, 32'h2000, 0, cyc, wecnt);
    chk("t2_lat", 32'(cyc), 32'(LAT));
    chk_res("t2", 8'd3, 32'h1234, 1'b1, 9'd2);

    // 3: nothing below target; word equal to target is not a match
    for (int k = 0; k < N; k++)
      wr(16'h0300 + 16'(k), (k == 5) ? 32'h10 : 32'h40 + 32'(15 - k));
    run_scan(16'h0300, 32'h10, 0, cyc, wecnt);
    chk_res("t3", 8'd5, 32'h10, 1'b0, 9'd0);

    // 4: restart attempt mid-scan is ignored (test 1 data)
    run_scan(16'h0000, 32'h60, 5, cyc, wecnt);
    chk("t4_lat", 32'(cyc), 32'(LAT));
    chk_res("t4", 8'd1, 32'h50, 1'b1, 9'd1);

    // Address wrap at top of memory; minimum at the last-ish nonce 10
    for (int k = 0; k < N; k++)
      wr(16'hFFF8 + 16'(k), (k == 10) ? 32'h5 : 32'h1000 + 32'(k));
    run_scan(16'hFFF8, 32'h1008, 0, cyc, wecnt);
    chk("wrap_lat", 32'(cyc), 32'(LAT));
    chk_res("wrap", 8'd10, 32'h5, 1'b1, 9'd9);

    // All-ones set: nonce 0 wins by default
    for (int k = 0; k < N; k++) wr(16'h0600 + 16'(k), 32'hFFFF_FFFF);
    run_scan(16'h0600, 32'hFFFF_FFFF, 0, cyc, wecnt);
    chk_res("ones", 8'd0, 32'hFFFF_FFFF, 1'b0, 9'd0);

    // 5: reset mid-scan, then fresh scan
    for (int k = 0; k < N; k++) wr(16'h0400 + 16'(k), (k == 2) ? 32'h1 : 32'hFFFF_FFFF);
    @(negedge clk); result_addr = 16'h0400; target = 32'h100; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (8) @(posedge clk);
    #1 reset_n = 1'b0;
    #1;
    chk("t5_rst_done", 32'(done), 32'd0);
    chk("t5_rst_addr", 32'(mem_addr), 32'd0);
    chk("t5_rst_we", 32'(mem_we), 32'd0);
    chk_res("t5_rst", 8'd0, 32'hFFFF_FFFF, 1'b0, 9'd0);
    repeat (2) @(posedge clk);
    @(negedge clk) reset_n = 1'b1;
    for (int k = 0; k < N; k++) wr(16'h0500 + 16'(k), (k == 12) ? 32'h77 : 32'hFFFF_FFFF);
    run_scan(16'h0500, 32'h78, 0, cyc, wecnt);
    chk("t5_lat", 32'(cyc), 32'(LAT));
    chk_res("t5", 8'd12, 32'h77, 1'b1, 9'd1);

    // 6: writeback of the result words (or no writes in the default build)
    for (int k = 0; k < N; k++) wr(16'h0100 + 16'(k), 32'h3000 - 32'(k) * 32'h100);
    wr(16'h0110, 32'hDEAD_BEEF);
    wr(16'h0111, 32'hDEAD_BEEF);
    run_scan(16'h0100, 32'h2800, 0, cyc, wecnt);
    chk("t6_lat", 32'(cyc), 32'(LAT));
    chk("t6_we_cycles", 32'(wecnt), 32'(WE_EX));
    chk_res("t6", 8'd15, 32'h2100, 1'b1, 9'd7);
    @(posedge clk); #1;
`ifdef BEST_WRITEBACK_EN
    chk("t6_mem_nonce", mem[16'h0110], 32'd15);
    chk("t6_mem_hash", mem[16'h0111], 32'h2100);
`else
    chk("t6_mem_nonce", mem[16'h0110], 32'hDEAD_BEEF);
    chk("t6_mem_hash", mem[16'h0111], 32'hDEAD_BEEF);
`endif
    chk("t6_done_hold", 32'(done), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
